bf_pass_scheduler: RTL and testbench

BF_PASS_SCHEDULER -- requirements
Module: bf_pass_scheduler

---
 rtl/bf_pkg.sv | 14 +
 rtl/bf_edge_counter.sv | 38 +++
 rtl/bf_pass_scheduler.sv | 169 ++++++++++++++++
 tb/tb_bf_pass_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford scheduler and its relax/init engines.
package bf_pkg;
  localparam int IDX_W_DEF  = 13;
  localparam int PASS_W_DEF = 13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_PASS_END = 3'd4,
    S_DONE     = 3'd5
  } bf_state_e;
endpackage

// File: rtl/bf_edge_counter.sv
// Edge index register for the current pass, with clear/increment and a last-edge flag.
module bf_edge_counter
  import bf_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] num_edges,
  output logic [IDX_W-1:0] edge_idx,
  output logic             last
);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  logic [IDX_W-1:0] edge_idx_q, edge_idx_d;

  always_comb begin
    edge_idx_d = edge_idx_q;
    if (clear) begin
      edge_idx_d = '0;
    end else if (inc) begin
      edge_idx_d = edge_idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_idx_q <= '0;
    end else begin
      edge_idx_q <= edge_idx_d;
    end
  end

  assign edge_idx = edge_idx_q;
  assign last     = (edge_idx_q == (num_edges - IDX_ONE));
endmodule

// File: rtl/bf_pass_scheduler.sv
// Sequences Bellman-Ford relaxation passes over all edges, then one detection pass
// to flag a negative cycle; exits early when a pass changes nothing.
module bf_pass_scheduler
  import bf_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_nodes,
  input  logic [IDX_W-1:0]  num_edges,
  output logic              init_go,
  input  logic              init_done,
  output logic              edge_valid,
  input  logic              edge_ready,
  output logic [IDX_W-1:0]  edge_idx,
  output logic              check_mode,
  input  logic              resp_valid,
  input  logic              resp_relaxed,
  output logic              busy,
  output logic              done,
  output logic              NegCycle,
  output logic [PASS_W-1:0] pass_count,
  output logic [2:0]        state_o
);
  localparam int CW = (IDX_W > PASS_W) ? IDX_W : PASS_W;
  localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
  localparam logic [PASS_W-1:0] PASS_ONE = 1;
  localparam logic [PASS_W-1:0] PASS_MAX = '1;

  bf_state_e         state_q, state_d;
  logic [IDX_W-1:0]  nodes_q, nodes_d, edges_q, edges_d;
  logic [PASS_W-1:0] pass_q, pass_d, pass_inc;
  logic              neg_q, neg_d, changed_q, changed_d, check_q, check_d;
  logic              init_go_q, init_go_d, valid_q, valid_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              idx_clear, idx_inc, idx_last, pass_reach;
  logic [IDX_W-1:0]  target;

  bf_edge_counter #(.IDX_W(IDX_W)) u_edge_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (idx_clear),
    .inc       (idx_inc),
    .num_edges (edges_q),
    .edge_idx  (edge_idx),
    .last      (idx_last)
  );

  // Pass counter saturates; reaching the max also forces the detection pass.
  assign target     = nodes_q - IDX_ONE;
  assign pass_inc   = (pass_q == PASS_MAX) ? pass_q : pass_q + PASS_ONE;
  assign pass_reach = (CW'(pass_inc) >= CW'(target)) || (pass_inc == PASS_MAX);

  // Request handshake: edge_valid rises in ISSUE and, with edge_idx and check_mode,
  // holds until the cycle edge_valid&edge_ready; one request is outstanding until
  // the single resp_valid cycle seen in WAIT.
  always_comb begin
    state_d   = state_q;
    nodes_d   = nodes_q;
    edges_d   = edges_q;
    pass_d    = pass_q;
    neg_d     = neg_q;
    changed_d = changed_q;
    check_d   = check_q;
    init_go_d = 1'b0;
    idx_clear = 1'b0;
    idx_inc   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          nodes_d   = num_nodes;
          edges_d   = num_edges;
          pass_d    = '0;
          neg_d     = 1'b0;
          changed_d = 1'b0;
          check_d   = 1'b0;
          init_go_d = 1'b1;
          idx_clear = 1'b1;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        if (init_done) begin
          if (nodes_q == '0 || edges_q == '0) begin
            state_d = S_DONE;
          end else begin
            check_d   = (nodes_q == IDX_ONE);
            idx_clear = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (edge_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid) begin
          changed_d = changed_q | resp_relaxed;
          if (idx_last) begin
            state_d = S_PASS_END;
          end else begin
            idx_inc = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_PASS_END: begin
        if (check_q) begin
          neg_d   = changed_q;
          state_d = S_DONE;
        end else begin
          pass_d = pass_inc;
          if (!changed_q) begin
            state_d = S_DONE;
          end else begin
            changed_d = 1'b0;
            idx_clear = 1'b1;
            if (pass_reach) check_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      nodes_q   <= '0;
      edges_q   <= '0;
      pass_q    <= '0;
      neg_q     <= 1'b0;
      changed_q <= 1'b0;
      check_q   <= 1'b0;
      init_go_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nodes_q   <= nodes_d;
      edges_q   <= edges_d;
      pass_q    <= pass_d;
      neg_q     <= neg_d;
      changed_q <= changed_d;
      check_q   <= check_d;
      init_go_q <= init_go_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign init_go    = init_go_q;
  assign edge_valid = valid_q;
  assign check_mode = check_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign NegCycle   = neg_q;
  assign pass_count = pass_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_bf_pass_scheduler.sv
// Bench for bf_pass_scheduler: table of runs, a request scoreboard, reset and stall sequences.
module tb_bf_pass_scheduler;
  import bf_pkg::*;

  localparam int IDX_W  = 13;
  localparam int PASS_W = 13;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  num_nodes = '0;
  logic [IDX_W-1:0]  num_edges = '0;
  logic              init_go;
  logic              init_done = 1'b0;
  logic              edge_valid;
  logic              edge_ready = 1'b0;
  logic [IDX_W-1:0]  edge_idx;
  logic              check_mode;
  logic              resp_valid = 1'b0;
  logic              resp_relaxed = 1'b0;
  logic              busy;
  logic              done;
  logic              NegCycle;
  logic [PASS_W-1:0] pass_count;
  logic [2:0]        state_o;

  always #5 clock = ~clock;

  bf_pass_scheduler #(.IDX_W(IDX_W), .PASS_W(PASS_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .num_nodes(num_nodes), .num_edges(num_edges),
    .init_go(init_go), .init_done(init_done),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_idx(edge_idx),
    .check_mode(check_mode), .resp_valid(resp_valid), .resp_relaxed(resp_relaxed),
    .busy(busy), .done(done), .NegCycle(NegCycle), .pass_count(pass_count),
    .state_o(state_o)
  );

  typedef struct {
    int nn;
    int ne;
    int mode;
    int stall_idx;
    int exp_pc;
    int exp_neg;
    int exp_chk;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [IDX_W:0] exp_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: every edge relaxes; 1: only the first pass relaxes; 2: nothing relaxes
  function automatic logic relax_of(input int mode, input int pass_no);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (pass_no == 0);
    return 1'b0;
  endfunction

  task automatic model_push(input int nn, input int ne, input int mode);
    int pc = 0;
    int pn = 0;
    logic chk;
    logic ch;
    chk = (nn == 1);
    if (nn == 0 || ne == 0) return;
    while (1) begin
      ch = 1'b0;
      for (int e = 0; e < ne; e++) begin
        exp_q.push_back({chk, IDX_W'(e)});
        ch = ch | relax_of(mode, pn);
      end
      pn++;
      if (chk) break;
      pc++;
      if (!ch) break;
      if (pc >= nn - 1) chk = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " edge_valid"}, edge_valid, 0);
    check({tag, " edge_idx"}, edge_idx, 0);
    check({tag, " check_mode"}, check_mode, 0);
    check({tag, " init_go"}, init_go, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " NegCycle"}, NegCycle, 0);
    check({tag, " pass_count"}, pass_count, 0);
    check({tag, " state"}, state_o, S_IDLE);
  endtask

  task automatic run_case(input int nn, input int ne, input int mode, input int stall_idx,
                          input bit rnd, input int abort_hs, input int exp_pc,
                          input int exp_neg, input int exp_chk, input string tag);
    int hs = 0;
    int cyc = 0;
    int dly;
    bit stall_pending;
    bit saw_chk = 0;
    logic [IDX_W:0] exp_e;
    logic rel;
    stall_pending = (stall_idx >= 0);
    exp_q.delete();
    model_push(nn, ne, mode);
    num_nodes = IDX_W'(nn);
    num_edges = IDX_W'(ne);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, " init_go pulse"}, init_go, 1);
    check({tag, " busy in init"}, busy, 1);
    check({tag, " pass_count cleared"}, pass_count, 0);
    check({tag, " NegCycle cleared"}, NegCycle, 0);
    check({tag, " done cleared"}, done, 0);
    init_done = 1'b1;
    @(posedge clock); #1;
    init_done = 1'b0;
    check({tag, " init_go single cycle"}, init_go, 0);
    while (done !== 1'b1 && cyc < 2000) begin
      if (edge_valid === 1'b1) begin
        if (stall_pending && edge_idx == IDX_W'(stall_idx)) begin
          for (int k = 0; k < 5; k++) begin
            check({tag, " stall valid"}, edge_valid, 1);
            check({tag, " stall idx"}, edge_idx, stall_idx);
            @(posedge clock); #1;
          end
          stall_pending = 0;
        end
        if (rnd) begin
          dly = $urandom_range(0, 2);
          for (int k = 0; k < dly; k++) begin
            @(posedge clock); #1;
          end
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s unexpected edge: got %0d expected none", tag, {check_mode, edge_idx});
        end else begin
          exp_e = exp_q.pop_front();
          check({tag, " edge request"}, {check_mode, edge_idx}, exp_e);
        end
        if (check_mode === 1'b1) saw_chk = 1;
        edge_ready = 1'b1;
        @(posedge clock); #1;
        edge_ready = 1'b0;
        check({tag, " no valid in wait"}, edge_valid, 0);
        rel = relax_of(mode, hs / ne);
        hs++;
        if (abort_hs > 0 && hs == abort_hs) return;
        resp_valid = 1'b1;
        resp_relaxed = rel;
        @(posedge clock); #1;
        resp_valid = 1'b0;
        resp_relaxed = 1'b0;
        if (!rnd && (hs % ne) != 0) check({tag, " back-to-back issue"}, edge_valid, 1);
        else if ((hs % ne) == 0) check({tag, " pass end state"}, state_o, S_PASS_END);
      end else begin
        @(posedge clock); #1;
      end
      cyc++;
    end
    if (abort_hs > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s abort point: got %0d handshakes expected %0d", tag, hs, abort_hs);
    end
    check({tag, " done (cycle budget)"}, done, 1);
    check({tag, " busy in done"}, busy, 0);
    check({tag, " edge_valid in done"}, edge_valid, 0);
    check({tag, " NegCycle"}, NegCycle, exp_neg);
    check({tag, " pass_count"}, pass_count, exp_pc);
    check({tag, " missing edges"}, exp_q.size(), 0);
    check({tag, " check pass seen"}, saw_chk, exp_chk);
  endtask

  initial begin
    int nn;
    int ne;
    vecs[0] = '{4, 3, 0, -1, 3, 1, 1};
    vecs[1] = '{5, 4, 1, -1, 2, 0, 0};
    vecs[2] = '{3, 0, 0, -1, 0, 0, 0};
    vecs[3] = '{4, 3, 0,  1, 3, 1, 1};
    vecs[4] = '{1, 1, 0, -1, 0, 1, 1};
    vecs[5] = '{3, 2, 2, -1, 1, 0, 0};
    vecs[6] = '{3, 2, 0, -1, 2, 1, 1};
    vecs[7] = '{0, 5, 0, -1, 0, 0, 0};
    vecs[8] = '{1, 1, 2, -1, 0, 0, 1};

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    check_zero("after release");

    for (int i = 0; i < 9; i++) begin
      run_case(vecs[i].nn, vecs[i].ne, vecs[i].mode, vecs[i].stall_idx, 1'b0, 0,
               vecs[i].exp_pc, vecs[i].exp_neg, vecs[i].exp_chk, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      nn = $urandom_range(2, 6);
      ne = $urandom_range(1, 5);
      run_case(nn, ne, 0, -1, 1'b1, 0, nn - 1, 1, 1, $sformatf("rnd%0d", i));
    end

    run_case(4, 3, 0, -1, 1'b0, 5, 0, 0, 0, "rst_mid");
    reset = 1'b0;
    #2;
    check_zero("async reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_case(4, 3, 0, -1, 1'b0, 0, 3, 1, 1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
